// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests and buffers
// in-order responses. Define FETCH_STATS_EN to add the fetch/redirect event counters.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             StallF,
  output logic             ValidF,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus4F
`ifdef FETCH_STATS_EN
  ,
  output logic [WIDTH-1:0] fetch_cnt_o,
  output logic [WIDTH-1:0] redirect_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    out_cnt;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    rq_cnt;

  logic [WIDTH-1:0] tag_mem [DEPTH];
  logic [AW-1:0]    tag_rd;
  logic [AW-1:0]    tag_wr;

  logic [WIDTH-1:0] rq_pc   [DEPTH];
  logic [WIDTH-1:0] rq_data [DEPTH];
  logic [AW-1:0]    rq_rd;
  logic [AW-1:0]    rq_wr;

  logic             credit_ok;
  logic             req_fire;
  logic             rsp_drop;
  logic             rsp_push;
  logic             pop;
  logic [CW-1:0]    out_after_rsp;
  logic             unused_tgt;

  assign unused_tgt = ^PCTargetE[1:0];

  // Handshakes: a request transfers on a cycle where imem_req_valid and imem_req_ready
  // are both high; valid never depends on ready. Responses carry no ready and are always
  // accepted, which is safe because the credit counts in-flight plus queued words.
  always_comb begin
    credit_ok      = ({1'b0, out_cnt} + {1'b0, rq_cnt}) < DEPTH_C;
    imem_req_valid = rst_n && credit_ok && !PCSrcE;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_push       = imem_rsp_valid && (drop_cnt == '0) && !PCSrcE;
    ValidF         = (rq_cnt != '0) && !PCSrcE;
    pop            = ValidF && !StallF;
    out_after_rsp  = out_cnt - CW'(imem_rsp_valid);
    InstrF         = rq_data[rq_rd];
    PCF            = rq_pc[rq_rd];
    PCPlus4F       = rq_pc[rq_rd] + WIDTH'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      rq_rd    <= '0;
      rq_wr    <= '0;
      rq_cnt   <= '0;
    end else if (PCSrcE) begin
      // Everything still in flight after this cycle belongs to the wrong path.
      pc       <= {PCTargetE[WIDTH-1:2], 2'b00};
      out_cnt  <= out_after_rsp;
      drop_cnt <= out_after_rsp;
      tag_rd   <= '0;
      tag_wr   <= '0;
      rq_rd    <= '0;
      rq_wr    <= '0;
      rq_cnt   <= '0;
    end else begin
      if (req_fire) begin
        pc     <= pc + WIDTH'(4);
        tag_wr <= tag_wr + AW'(1);
      end
      out_cnt <= out_after_rsp + CW'(req_fire);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_push) begin
        tag_rd <= tag_rd + AW'(1);
        rq_wr  <= rq_wr + AW'(1);
      end
      if (pop) begin
        rq_rd <= rq_rd + AW'(1);
      end
      rq_cnt <= rq_cnt + CW'(rsp_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr] <= pc;
    end
  end

  // Storage is reset so the idle head reads PC 0 / instruction 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rq_pc[i]   <= '0;
        rq_data[i] <= '0;
      end
    end else if (rsp_push) begin
      rq_pc[rq_wr]   <= tag_mem[tag_rd];
      rq_data[rq_wr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o    <= '0;
      redirect_cnt_o <= '0;
    end else begin
      fetch_cnt_o    <= fetch_cnt_o + WIDTH'(pop);
      redirect_cnt_o <= redirect_cnt_o + WIDTH'(PCSrcE);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: modelled instruction memory (data = addr ^ A5A5A5A5), directed
// phases, and monitors that compare every popped instruction against an expected queue.
module tb_fetch_unit;

  localparam logic [31:0] K       = 32'hA5A5A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        PCSrcE, StallF, ValidF;
  logic [31:0] PCTargetE, InstrF, PCF, PCPlus4F;

  logic        w_req_valid, w_rsp_valid, w_validf;
  logic        w_req_ready = 1'b1;
  logic        w_pcsrc = 1'b0;
  logic        w_stall = 1'b0;
  logic [31:0] w_target = 32'h0;
  logic [31:0] w_req_addr, w_rsp_data, w_instr, w_pcf, w_pc4;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt, redirect_cnt, w_fetch_cnt, w_redirect_cnt;
`endif

  fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
`ifdef FETCH_STATS_EN
    , .fetch_cnt_o(fetch_cnt), .redirect_cnt_o(redirect_cnt)
`endif
  );

  fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .PCSrcE(w_pcsrc), .PCTargetE(w_target),
    .StallF(w_stall), .ValidF(w_validf), .InstrF(w_instr), .PCF(w_pcf), .PCPlus4F(w_pc4)
`ifdef FETCH_STATS_EN
    , .fetch_cnt_o(w_fetch_cnt), .redirect_cnt_o(w_redirect_cnt)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  bit          mon_on = 1'b0;
  bit          mon_w_on = 1'b0;
  int          pop_cnt = 0;
  int          req_cnt = 0;
  int          req_base = 0;
  int          pop_base = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] pend_a[$];
  int          pend_due[$];
  logic        mem_hs, w_hs;
  logic [31:0] mem_ha, w_ha, mon_e, mon_w_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mon_on = 1'b0;
    mon_w_on = 1'b0;
    exp_q.delete();
    exp_w_q.delete();
    step(2);
    chk("rst_validf", ValidF, 32'd0);
    chk("rst_req_valid", imem_req_valid, 32'd0);
    chk("rst_pcf", PCF, 32'd0);
    chk("rst_instrf", InstrF, 32'd0);
    chk("rst_pcplus4f", PCPlus4F, 32'd4);
`ifdef FETCH_STATS_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
    req_base = req_cnt;
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
  endtask

  task automatic wait_drain(input string name, input int n, input bit wrap_dut);
    int k = 0;
    while ((wrap_dut ? mon_w_on : mon_on) && k < n) begin
      step(1);
      k++;
    end
    chk(name, {31'b0, (wrap_dut ? mon_w_on : mon_on)}, 32'd0);
  endtask

  // Main memory: in-order responses, mem_lat cycles after the request handshake.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_a.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        mem_hs = 1'b0;
      end else begin
        mem_hs = imem_req_valid && imem_req_ready;
        mem_ha = imem_req_addr;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mem_hs) begin
        pend_a.push_back(mem_ha);
        pend_due.push_back(cyc + mem_lat);
        req_cnt++;
      end
      imem_rsp_valid = 1'b0;
      if (pend_a.size() > 0 && pend_due[0] <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_a.pop_front() ^ K;
        void'(pend_due.pop_front());
      end
    end
  end

  // Wrap-test memory: always ready, one-cycle latency.
  initial begin
    w_rsp_valid = 1'b0;
    w_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      w_hs = rst_n && w_req_valid;
      w_ha = w_req_addr;
      if (!rst_n) w_rsp_valid = 1'b0;
      @(posedge clk);
      #1;
      w_rsp_valid = w_hs;
      w_rsp_data  = w_ha ^ K;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ValidF && !StallF) begin
        pop_cnt++;
        if (mon_on) begin
          mon_e = exp_q.pop_front();
          chk("pcf", PCF, mon_e);
          chk("instrf", InstrF, mon_e ^ K);
          chk("pcplus4f", PCPlus4F, mon_e + 32'd4);
          if (exp_q.size() == 0) mon_on = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && w_validf && mon_w_on) begin
        mon_w_e = exp_w_q.pop_front();
        chk("wrap_pcf", w_pcf, mon_w_e);
        chk("wrap_instrf", w_instr, mon_w_e ^ K);
        chk("wrap_pcplus4f", w_pc4, mon_w_e + 32'd4);
        if (exp_w_q.size() == 0) mon_w_on = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem_req_ready = 1'b1;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    StallF = 1'b0;

    // Streaming from reset with a one-cycle memory.
    mem_lat = 1;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    mon_on = 1'b1;
    release_rst();
    step(2);
    for (int i = 0; i < 4; i++) begin
      chk("stream_validf", ValidF, 32'd1);
      step(1);
    end
    wait_drain("stream_drain", 10, 1'b0);

    // Stall back-pressure fills the queue, then drains without gaps.
    StallF = 1'b1;
    do_reset();
    release_rst();
    step(3);
    chk("stall_validf", ValidF, 32'd1);
    chk("stall_head_pc", PCF, 32'h0);
    step(3);
    chk("credit_limit", 32'(req_cnt - req_base), 32'd4);
    chk("stall_head_pc_held", PCF, 32'h0);
    chk("full_no_req", imem_req_valid, 32'd0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    mon_on = 1'b1;
    pop_base = pop_cnt;
    StallF = 1'b0;
    step(6);
    chk("no_gap_pops", 32'(pop_cnt - pop_base), 32'd6);
`ifdef FETCH_STATS_EN
    chk("fetch_cnt", fetch_cnt, 32'd6);
`endif
    wait_drain("stall_drain", 5, 1'b0);

    // Redirect with three requests in flight on a three-cycle memory.
    mem_lat = 3;
    do_reset();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    mon_on = 1'b1;
    release_rst();
    step(3);
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    #1;
    chk("redir_no_req", imem_req_valid, 32'd0);
    chk("redir_validf", ValidF, 32'd0);
    step(1);
    PCSrcE = 1'b0;
    #1;
    chk("redir_req_valid", imem_req_valid, 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    wait_drain("redir_drain", 30, 1'b0);

    // Redirect while the head is stalled; low target bits are ignored.
    mem_lat = 1;
    StallF = 1'b1;
    do_reset();
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    mon_on = 1'b1;
    release_rst();
    step(3);
    chk("held_validf", ValidF, 32'd1);
    chk("held_pcf", PCF, 32'h0);
    PCSrcE = 1'b1;
    PCTargetE = 32'h203;
    #1;
    chk("held_hidden", ValidF, 32'd0);
    step(1);
    PCSrcE = 1'b0;
    StallF = 1'b0;
    #1;
    chk("aligned_req_addr", imem_req_addr, 32'h200);
    wait_drain("held_drain", 20, 1'b0);
`ifdef FETCH_STATS_EN
    chk("redirect_cnt", redirect_cnt, 32'd1);
`endif
    PCTargetE = 32'h0;

    // PC wrap from the top of the address space.
    do_reset();
    exp_w_q.push_back(WRAP_PC); exp_w_q.push_back(32'hFFFFFFFC); exp_w_q.push_back(32'h0);
    mon_w_on = 1'b1;
    release_rst();
    chk("wrap_first_addr", w_req_addr, WRAP_PC);
    wait_drain("wrap_drain", 20, 1'b1);

    // Reset pulsed while the queue is full.
    StallF = 1'b1;
    do_reset();
    release_rst();
    step(6);
    chk("full_validf", ValidF, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_validf", ValidF, 32'd0);
    chk("midrst_req_valid", imem_req_valid, 32'd0);
    chk("midrst_pcf", PCF, 32'h0);
`ifdef FETCH_STATS_EN
    chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
    chk("midrst_redirect_cnt", redirect_cnt, 32'd0);
`endif
    step(2);
    StallF = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    mon_on = 1'b1;
    release_rst();
    wait_drain("midrst_drain", 20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
